mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum memory-wait cycles before abort.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports if_req in 1, if_addr in ADDR_W: instruction-fetch read request (read-only), held until if_ready.
REQ-007 SHALL have ports if_rdata out DATA_W, if_ready out 1: fetch data and one-cycle completion pulse.
REQ-008 SHALL have ports d_req in 1, d_we in 1, d_addr in ADDR_W, d_wdata in DATA_W: data-stage request, held until d_ready.
REQ-009 SHALL have ports d_rdata out DATA_W, d_ready out 1: load data and one-cycle completion pulse.
REQ-010 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W, mem_ready in 1: single shared memory port.
REQ-011 SHALL have port err out 1: sticky timeout flag.

Function
REQ-012 SHALL implement FSM states IDLE, IF_BUSY, D_BUSY, DONE.
REQ-013 IDLE: if any request is pending, SHALL grant one, latch its addr/we/wdata into registers, and move to IF_BUSY or D_BUSY; otherwise stay.
REQ-014 Both pending, macro absent: d_req SHALL win (fixed priority, older instruction first).
REQ-015 IF_BUSY/D_BUSY: mem_req=1 with latched addr/we/wdata every cycle; if fetch, mem_we=0.
REQ-016 mem_ready=1 in busy state: SHALL register mem_rdata into granted requester's rdata (writes: rdata unchanged) and move to DONE.
REQ-017 DONE: granted requester's ready=1 for exactly this cycle; mem_req=0; no new grant; next state IDLE.
REQ-018 Minimum latency: req seen cycle 0, mem_req cycle 1, mem_ready cycle 1, ready cycle 2, next grant earliest cycle 3.
REQ-019 mem_ready outside busy states SHALL be ignored.
REQ-020 Wait counter SHALL clear on grant and increment each busy cycle without mem_ready; on reaching TIMEOUT, SHALL set err, load rdata=0, go to DONE (ready pulse still issued).
REQ-021 err SHALL stay set until reset; later transactions proceed normally.
REQ-022 Requests dropped mid-transaction SHALL NOT abort it; ready still pulses.
REQ-023 Unused outputs (mem_addr, mem_wdata when idle) SHALL hold last latched value; mem_we=0 outside busy.

Reset
REQ-024 reset, sampled on clk edge, SHALL force state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ready=0, d_ready=0, if_rdata=0, d_rdata=0, err=0, counter=0, last-grant=IF.
REQ-025 reset mid-transaction SHALL abandon it with no ready pulse; reset dominates all other inputs.

Configuration
REQ-026 Macro MEM_ARB_RR_EN defined: both pending in IDLE, SHALL grant the requester not granted last (last-grant register updated on each grant).
REQ-027 MEM_ARB_RR_EN undefined: fixed priority per REQ-014; last-grant register absent.

Structure
REQ-028 Shared package SHALL hold the FSM state enum, grant-id encoding (GNT_IF, GNT_D), default widths.
REQ-029 Single module; timeout counter MAY be sub-module mem_arb_timer (clear, enable, expired).

Verification
REQ-030 Lone fetch: if_req=1, if_addr=0x40, mem_ready on first busy cycle with rdata 0x12345678 -> mem_addr=0x40 cycle 1, if_ready and if_rdata=0x12345678 cycle 2.
REQ-031 Simultaneous if_req+d_req (d_we=1, d_addr=0x100, d_wdata=0xA5) fixed priority -> store issued first (mem_we=1, addr 0x100), d_ready, then fetch granted cycle 3.
REQ-032 MEM_ARB_RR_EN, both requesters held for 4 transactions -> grants alternate D,IF,D,IF.
REQ-033 mem_ready never asserted, TIMEOUT=8 -> err=1 after 8 busy cycles, ready pulse with rdata=0, err persists until reset.
REQ-034 reset asserted during D_BUSY -> next cycle mem_req=0, no d_ready, all outputs at reset values.
REQ-035 Stray mem_ready in IDLE/DONE -> no state change, no ready pulse.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the two-requester memory port arbiter:
//   - default address/data widths and wait timeout
//   - FSM state encoding
//   - grant identifiers (instruction fetch vs. data stage)
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer
// Memory-wait counter. Counts busy cycles in which the memory has not yet
// answered; expired is asserted combinationally on the TIMEOUT-th such cycle.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clear       - restart the count (on every grant)
//   enable      - a busy cycle without mem_ready
//   expired     - this enabled cycle is the TIMEOUT-th one
module mem_arb_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count;

  // Count holds the number of earlier waiting cycles, so the TIMEOUT-th
  // waiting cycle sees TIMEOUT-1.
  assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between an instruction-fetch requester (read-only)
// and a data-stage requester (read/write). One transaction at a time: grant,
// wait for mem_ready (or timeout), one-cycle ready pulse, back to idle.
// Ports:
//   clk, reset                              - clock, synchronous active-high reset
//   if_req, if_addr, if_rdata, if_ready     - fetch request / completion
//   d_req, d_we, d_addr, d_wdata,
//   d_rdata, d_ready                        - data-stage request / completion
//   mem_req, mem_we, mem_addr, mem_wdata,
//   mem_rdata, mem_ready                    - shared memory port
//   err                                     - sticky timeout flag
// Build option: MEM_ARB_RR_EN selects round-robin between simultaneous
// requesters; without it the data stage always wins.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | no transaction; grant any pending request
// IF_BUSY | fetch on the memory port, waiting for mem_ready
// D_BUSY  | data access on the memory port, waiting for mem_ready
// DONE    | ready pulse to the granted requester, no grant
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  arb_state_t        state, state_nxt;
  gnt_t              grant_id;
  gnt_t              done_gnt;
  logic              grant_en;
  logic              busy;
  logic              tmr_expired;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;

`ifdef MEM_ARB_RR_EN
  gnt_t              last_gnt;
`endif

  assign busy      = (state == IF_BUSY) || (state == D_BUSY);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  mem_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (grant_en),
    .enable  (busy && !mem_ready),
    .expired (tmr_expired)
  );

  // Arbitration; only consulted in IDLE.
  always_comb begin
    grant_id = GNT_IF;
`ifdef MEM_ARB_RR_EN
    if (if_req && d_req) begin
      grant_id = (last_gnt == GNT_D) ? GNT_IF : GNT_D;
    end else if (d_req) begin
      grant_id = GNT_D;
    end
`else
    if (d_req) begin
      grant_id = GNT_D;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    if_ready  = 1'b0;
    d_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          grant_en  = 1'b1;
          state_nxt = (grant_id == GNT_D) ? D_BUSY : IF_BUSY;
        end
      end
      IF_BUSY: begin
        mem_req = 1'b1;
        if (mem_ready || tmr_expired) state_nxt = DONE;
      end
      D_BUSY: begin
        mem_req = 1'b1;
        mem_we  = we_q;
        if (mem_ready || tmr_expired) state_nxt = DONE;
      end
      DONE: begin
        if_ready  = (done_gnt == GNT_IF);
        d_ready   = (done_gnt == GNT_D);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      done_gnt <= GNT_IF;
      if_rdata <= '0;
      d_rdata  <= '0;
      err      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_gnt <= GNT_IF;
`endif
    end else begin
      if (grant_en) begin
        done_gnt <= grant_id;
`ifdef MEM_ARB_RR_EN
        last_gnt <= grant_id;
`endif
        if (grant_id == GNT_D) begin
          addr_q  <= d_addr;
          we_q    <= d_we;
          wdata_q <= d_wdata;
        end else begin
          // Fetches carry no write data; mem_wdata keeps the last store value.
          addr_q  <= if_addr;
          we_q    <= 1'b0;
        end
      end
      if (busy) begin
        if (mem_ready) begin
          if (state == IF_BUSY) begin
            if_rdata <= mem_rdata;
          end else if (!we_q) begin
            d_rdata <= mem_rdata;
          end
        end else if (tmr_expired) begin
          err <= 1'b1;
          if (state == IF_BUSY) begin
            if_rdata <= '0;
          end else begin
            d_rdata <= '0;
          end
        end
      end
    end
  end

endmodule
